// File: rtl/vectored_irq_controller.sv
// Vectored, prioritised, maskable interrupt controller with single-level servicing.
// Redirects the PC to a per-channel vector and restores PC/flags on return.
module vectored_irq_controller #(
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned NUM_IRQ      = 4,
    parameter int unsigned ID_W         = 2,
    parameter int unsigned VEC_BASE     = 'hF0,
    parameter int unsigned VEC_STRIDE   = 4,
    parameter int unsigned FLUSH_CYCLES = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               mask_we,
    input  logic [NUM_IRQ-1:0] mask_data,
    input  logic               ie_set,
    input  logic               ie_clr,
    input  logic               reti,
    input  logic               stall,
    input  logic [ADDR_W-1:0]  cur_pc,
    input  logic [3:0]         flags_in,
    output logic               pc_take,
    output logic [ADDR_W-1:0]  jmp_addr,
    output logic               flags_restore,
    output logic [3:0]         flags_out,
    output logic               in_service,
    output logic [ID_W-1:0]    active_id,
    output logic [NUM_IRQ-1:0] pending,
    output logic               ie
);

    localparam int unsigned CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FLUSH,
        S_VECTOR,
        S_SERVICE,
        S_RETURN
    } state_t;

    state_t              state, state_nxt;
    logic [NUM_IRQ-1:0]  irq_q;
    logic [NUM_IRQ-1:0]  mask;
    logic [NUM_IRQ-1:0]  rise;
    logic [NUM_IRQ-1:0]  cand;
    logic [NUM_IRQ-1:0]  win_onehot;
    logic [ID_W-1:0]     win_id;
    logic [CNT_W-1:0]    cnt;
    logic [ADDR_W-1:0]   saved_pc;
    logic [3:0]          saved_flags;
    logic [ADDR_W-1:0]   vec_addr;
    logic                accept;

    assign rise     = irq & ~irq_q;
    assign cand     = pending & mask;
    assign accept   = (state == S_IDLE) && ie && (|cand) && !stall;
    assign vec_addr = ADDR_W'(VEC_BASE + VEC_STRIDE * active_id);

    // Scan from the top down so the lowest-index candidate is the last to overwrite.
    always_comb begin
        win_id     = '0;
        win_onehot = '0;
        for (int unsigned i = NUM_IRQ; i > 0; i--) begin
            if (cand[i-1]) begin
                win_id          = ID_W'(i - 1);
                win_onehot      = '0;
                win_onehot[i-1] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        pc_take       = 1'b0;
        jmp_addr      = '0;
        flags_restore = 1'b0;
        flags_out     = '0;
        in_service    = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (accept) state_nxt = S_FLUSH;
            end
            S_FLUSH: begin
                if (cnt == '0) state_nxt = S_VECTOR;
            end
            S_VECTOR: begin
                pc_take   = 1'b1;
                jmp_addr  = vec_addr;
                state_nxt = S_SERVICE;
            end
            S_SERVICE: begin
                if (reti) state_nxt = S_RETURN;
            end
            S_RETURN: begin
                pc_take       = 1'b1;
                jmp_addr      = saved_pc;
                flags_restore = 1'b1;
                flags_out     = saved_flags;
                state_nxt     = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_q       <= '0;
            mask        <= '1;
            pending     <= '0;
            ie          <= 1'b0;
            active_id   <= '0;
            saved_pc    <= '0;
            saved_flags <= '0;
            cnt         <= '0;
        end else begin
            irq_q <= irq;
            if (mask_we) mask <= mask_data;
            // A fresh edge on the channel being accepted keeps it pending.
            pending <= (pending & ~(accept ? win_onehot : '0)) | rise;
            if (accept) begin
                saved_pc    <= cur_pc;
                saved_flags <= flags_in;
                active_id   <= win_id;
                ie          <= 1'b0;
                cnt         <= CNT_W'(FLUSH_CYCLES - 1);
            end else if (state == S_IDLE) begin
                if (ie_clr) begin
                    ie <= 1'b0;
                end else if (ie_set) begin
                    ie <= 1'b1;
                end
            end else if (state == S_RETURN) begin
                ie <= 1'b1;
            end
            if (state == S_FLUSH && cnt != '0) cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: tb/tb_vectored_irq_controller.sv
// Self-checking bench: directed table, hand-written corner sequences and
// randomized traffic against a cycle-age reference model.
module tb_vectored_irq_controller;

    localparam int F = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] irq;
    logic       mask_we;
    logic [3:0] mask_data;
    logic       ie_set, ie_clr, reti, stall;
    logic [7:0] cur_pc;
    logic [3:0] flags_in;
    logic       pc_take;
    logic [7:0] jmp_addr;
    logic       flags_restore;
    logic [3:0] flags_out;
    logic       in_service;
    logic [1:0] active_id;
    logic [3:0] pending;
    logic       ie;

    int n_cmp = 0;
    int n_err = 0;

    vectored_irq_controller #(
        .ADDR_W(8), .NUM_IRQ(4), .ID_W(2), .VEC_BASE('hF0), .VEC_STRIDE(4), .FLUSH_CYCLES(F)
    ) dut (
        .clk(clk), .reset(reset), .irq(irq), .mask_we(mask_we), .mask_data(mask_data),
        .ie_set(ie_set), .ie_clr(ie_clr), .reti(reti), .stall(stall), .cur_pc(cur_pc),
        .flags_in(flags_in), .pc_take(pc_take), .jmp_addr(jmp_addr),
        .flags_restore(flags_restore), .flags_out(flags_out), .in_service(in_service),
        .active_id(active_id), .pending(pending), .ie(ie)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_take(input int budget, output int n);
        n = 0;
        while (pc_take !== 1'b1 && n < budget) begin
            cycle();
            n++;
        end
        chk("pc_take_seen", 32'(pc_take), 32'd1);
    endtask

    // Reference model: m_age counts cycles since acceptance (1..F flush,
    // F+1 vector, F+2 waiting for reti); m_ret marks the return cycle.
    int         m_age;
    bit         m_ret;
    bit         m_ie;
    int         m_id;
    logic [3:0] m_pend, m_mask, m_prev, m_sfl;
    logic [7:0] m_spc;

    function automatic logic [7:0] vec(input int id);
        return 8'(240 + id * 4);
    endfunction

    task automatic model_reset();
        m_age = 0; m_ret = 0; m_ie = 0; m_id = 0;
        m_pend = '0; m_mask = '1; m_prev = '0; m_sfl = '0; m_spc = '0;
    endtask

    task automatic model_compare();
        logic       e_take;
        logic [7:0] e_jmp;
        e_take = (m_age == F + 1) || m_ret;
        e_jmp  = (m_age == F + 1) ? vec(m_id) : (m_ret ? m_spc : 8'h00);
        chk("rnd_pc_take", 32'(pc_take), 32'(e_take));
        chk("rnd_jmp_addr", 32'(jmp_addr), 32'(e_jmp));
        chk("rnd_flags_restore", 32'(flags_restore), 32'(m_ret));
        chk("rnd_flags_out", 32'(flags_out), 32'(m_ret ? m_sfl : 4'h0));
        chk("rnd_in_service", 32'(in_service), 32'((m_age != 0) || m_ret));
        chk("rnd_active_id", 32'(active_id), 32'(m_id));
        chk("rnd_pending", 32'(pending), 32'(m_pend));
        chk("rnd_ie", 32'(ie), 32'(m_ie));
    endtask

    task automatic model_step();
        logic [3:0] rise;
        rise   = irq & ~m_prev;
        m_prev = irq;
        if (m_age == 0 && !m_ret) begin
            if (m_ie && (m_pend & m_mask) != 4'b0 && !stall) begin
                for (int i = 0; i < 4; i++) begin
                    if (m_pend[i] && m_mask[i]) begin
                        m_id = i;
                        break;
                    end
                end
                m_pend[m_id] = 1'b0;
                m_spc = cur_pc;
                m_sfl = flags_in;
                m_ie  = 0;
                m_age = 1;
            end else if (ie_clr) begin
                m_ie = 0;
            end else if (ie_set) begin
                m_ie = 1;
            end
        end else if (m_ret) begin
            m_ret = 0;
            m_ie  = 1;
        end else if (m_age <= F + 1) begin
            m_age++;
        end else if (reti) begin
            m_age = 0;
            m_ret = 1;
        end
        m_pend = m_pend | rise;
        if (mask_we) m_mask = mask_data;
    endtask

    typedef struct {
        logic [3:0] irq;
        logic       ie_set;
        logic       reti;
        logic       e_take;
        logic [7:0] e_jmp;
        logic       e_ie;
        logic [3:0] e_pend;
        logic       e_svc;
        logic       e_fr;
        logic [3:0] e_fo;
    } vec_t;

    vec_t tbl [10];
    int   n;
    bit   seen;

    initial begin
        //         irq     set reti take jmp    ie pend    svc fr fo
        tbl[0] = '{4'b0000, 1, 0,   0, 8'h00, 0, 4'b0000, 0, 0, 4'h0};
        tbl[1] = '{4'b0100, 0, 0,   0, 8'h00, 1, 4'b0000, 0, 0, 4'h0};
        tbl[2] = '{4'b0000, 0, 0,   0, 8'h00, 1, 4'b0100, 0, 0, 4'h0};
        tbl[3] = '{4'b0000, 0, 0,   0, 8'h00, 0, 4'b0000, 1, 0, 4'h0};
        tbl[4] = '{4'b0000, 0, 1,   0, 8'h00, 0, 4'b0000, 1, 0, 4'h0};
        tbl[5] = '{4'b0000, 0, 0,   0, 8'h00, 0, 4'b0000, 1, 0, 4'h0};
        tbl[6] = '{4'b0000, 0, 0,   1, 8'hF8, 0, 4'b0000, 1, 0, 4'h0};
        tbl[7] = '{4'b0000, 0, 1,   0, 8'h00, 0, 4'b0000, 1, 0, 4'h0};
        tbl[8] = '{4'b0000, 0, 0,   1, 8'h35, 0, 4'b0000, 1, 1, 4'hA};
        tbl[9] = '{4'b0000, 0, 0,   0, 8'h00, 1, 4'b0000, 0, 0, 4'h0};

        reset = 1; irq = '0; mask_we = 0; mask_data = '0; ie_set = 0; ie_clr = 0;
        reti = 0; stall = 0; cur_pc = 8'h35; flags_in = 4'b1010;
        cycle();
        cycle();
        chk("rst_pc_take", 32'(pc_take), 32'd0);
        chk("rst_jmp_addr", 32'(jmp_addr), 32'd0);
        chk("rst_flags_restore", 32'(flags_restore), 32'd0);
        chk("rst_flags_out", 32'(flags_out), 32'd0);
        chk("rst_in_service", 32'(in_service), 32'd0);
        chk("rst_active_id", 32'(active_id), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_ie", 32'(ie), 32'd0);
        reset = 0;
        cycle();

        // Single request on channel 2, then return.
        for (int i = 0; i < 10; i++) begin
            irq = tbl[i].irq; ie_set = tbl[i].ie_set; reti = tbl[i].reti;
            chk($sformatf("tbl%0d_pc_take", i), 32'(pc_take), 32'(tbl[i].e_take));
            chk($sformatf("tbl%0d_jmp_addr", i), 32'(jmp_addr), 32'(tbl[i].e_jmp));
            chk($sformatf("tbl%0d_ie", i), 32'(ie), 32'(tbl[i].e_ie));
            chk($sformatf("tbl%0d_pending", i), 32'(pending), 32'(tbl[i].e_pend));
            chk($sformatf("tbl%0d_in_service", i), 32'(in_service), 32'(tbl[i].e_svc));
            chk($sformatf("tbl%0d_flags_restore", i), 32'(flags_restore), 32'(tbl[i].e_fr));
            chk($sformatf("tbl%0d_flags_out", i), 32'(flags_out), 32'(tbl[i].e_fo));
            cycle();
        end
        irq = '0; ie_set = 0; reti = 0;

        // Simultaneous edges on channels 3 and 1.
        irq = 4'b1010;
        cycle();
        irq = '0;
        wait_take(10, n);
        chk("prio_jmp_addr", 32'(jmp_addr), 32'hF4);
        chk("prio_active_id", 32'(active_id), 32'd1);
        chk("prio_pending3", 32'(pending), 32'b1000);
        cycle();
        chk("prio_service", 32'(in_service), 32'd1);
        reti = 1;
        cycle();
        reti = 0;
        chk("prio_ret_take", 32'(pc_take), 32'd1);
        chk("prio_ret_jmp", 32'(jmp_addr), 32'h35);
        cycle();
        chk("post_ret_idle", 32'(in_service), 32'd0);
        chk("post_ret_pending", 32'(pending), 32'b1000);
        chk("post_ret_ie", 32'(ie), 32'd1);
        wait_take(10, n);
        chk("post_ret_latency", 32'(n), 32'd4);
        chk("post_ret_jmp", 32'(jmp_addr), 32'hFC);
        chk("post_ret_active_id", 32'(active_id), 32'd3);
        chk("post_ret_pending0", 32'(pending), 32'd0);
        cycle();
        reti = 1;
        cycle();
        reti = 0;
        cycle();

        // Masked channel latches but is not accepted until unmasked.
        mask_we = 1; mask_data = 4'b1110;
        cycle();
        mask_we = 0;
        irq = 4'b0001;
        cycle();
        irq = '0;
        repeat (4) cycle();
        chk("mask_pending", 32'(pending), 32'b0001);
        chk("mask_no_accept", 32'(in_service), 32'd0);
        mask_we = 1; mask_data = 4'b1111;
        cycle();
        mask_we = 0;
        wait_take(10, n);
        chk("unmask_latency", 32'(n), 32'd4);
        chk("unmask_jmp", 32'(jmp_addr), 32'hF0);
        cycle();
        reti = 1;
        cycle();
        reti = 0;
        cycle();

        // ie_clr priority and stall blocking acceptance.
        ie_clr = 1;
        cycle();
        ie_clr = 0;
        chk("ie_clr", 32'(ie), 32'd0);
        irq = 4'b0010;
        cycle();
        irq = '0;
        cycle();
        chk("ie_off_pending", 32'(pending), 32'b0010);
        chk("ie_off_idle", 32'(in_service), 32'd0);
        ie_set = 1; ie_clr = 1;
        cycle();
        ie_set = 0; ie_clr = 0;
        chk("ie_clr_prio", 32'(ie), 32'd0);
        stall = 1; ie_set = 1;
        cycle();
        ie_set = 0;
        repeat (3) begin
            chk("stall_ie", 32'(ie), 32'd1);
            chk("stall_idle", 32'(in_service), 32'd0);
            chk("stall_pending", 32'(pending), 32'b0010);
            cycle();
        end
        stall = 0;
        cycle();
        chk("unstall_accept", 32'(in_service), 32'd1);
        chk("unstall_ie", 32'(ie), 32'd0);
        chk("unstall_id", 32'(active_id), 32'd1);

        // Reset while flushing aborts the redirect.
        reset = 1;
        #1;
        chk("abort_pc_take", 32'(pc_take), 32'd0);
        chk("abort_in_service", 32'(in_service), 32'd0);
        chk("abort_ie", 32'(ie), 32'd0);
        chk("abort_pending", 32'(pending), 32'd0);
        chk("abort_active_id", 32'(active_id), 32'd0);
        chk("abort_jmp", 32'(jmp_addr), 32'd0);
        seen = 0;
        repeat (2) begin
            if (pc_take) seen = 1;
            cycle();
        end
        reset = 0;
        for (int i = 0; i < 6; i++) begin
            if (pc_take) seen = 1;
            cycle();
        end
        chk("abort_no_take", 32'(seen), 32'd0);
        ie_set = 1;
        cycle();
        ie_set = 0;
        irq = 4'b0100;
        cycle();
        irq = '0;
        wait_take(10, n);
        chk("after_abort_latency", 32'(n), 32'd4);
        chk("after_abort_jmp", 32'(jmp_addr), 32'hF8);
        cycle();
        reti = 1;
        cycle();
        reti = 0;

        // Randomized traffic against the reference model.
        for (int c = 0; c < 3000; c++) begin
            reset     = (c == 0) || ($urandom_range(0, 299) == 0);
            irq       = irq ^ (($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000);
            ie_set    = ($urandom_range(0, 7) == 0);
            ie_clr    = ($urandom_range(0, 31) == 0);
            reti      = ($urandom_range(0, 3) == 0);
            stall     = ($urandom_range(0, 3) == 0);
            mask_we   = ($urandom_range(0, 15) == 0);
            mask_data = 4'($urandom);
            cur_pc    = 8'($urandom);
            flags_in  = 4'($urandom);
            #1;
            if (reset) model_reset();
            model_compare();
            if (!reset) model_step();
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
